// File: rtl/pynq_z2_pkg.sv
// Shared constants for the Pynq-Z2 board I/O peripheral: register map, AXI
// response codes, INFO field layout and the AXI channel state encoding.
package pynq_z2_pkg;

  localparam logic [7:0] ADDR_BTN_STATE  = 8'h00;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h04;
  localparam logic [7:0] ADDR_IRQ_ENABLE = 8'h08;
  localparam logic [7:0] ADDR_INFO       = 8'h0C;
  localparam logic [7:0] ADDR_LED_DUTY   = 8'h10;

  localparam logic [5:0] W_BTN_STATE  = ADDR_BTN_STATE[7:2];
  localparam logic [5:0] W_IRQ_STATUS = ADDR_IRQ_STATUS[7:2];
  localparam logic [5:0] W_IRQ_ENABLE = ADDR_IRQ_ENABLE[7:2];
  localparam logic [5:0] W_INFO       = ADDR_INFO[7:2];
  localparam logic [5:0] W_LED_DUTY   = ADDR_LED_DUTY[7:2];

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int INFO_PWM_LSB = 0;
  localparam int INFO_BTN_LSB = 8;
  localparam int INFO_LED_LSB = 16;

  typedef enum logic [1:0] {
    AXI_IDLE,
    AXI_READY,
    AXI_RESP
  } axi_ch_t;

  function automatic logic [31:0] info_word(input int n_led, input int n_btn, input int pwm_w);
    logic [31:0] w;
    w = '0;
    w[INFO_LED_LSB +: 8] = n_led[7:0];
    w[INFO_BTN_LSB +: 8] = n_btn[7:0];
    w[INFO_PWM_LSB +: 8] = pwm_w[7:0];
    return w;
  endfunction

endpackage

// File: rtl/pynq_z2_debounce.sv
// One debounced input channel: 2-FF synchroniser, stability counter, accepted
// level and a one-cycle pulse when the accepted level rises.
module pynq_z2_debounce #(
  parameter int DB_CYCLES = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
      cnt     <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], din};
      rise    <= 1'b0;
      if (sync_ff[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_ff[1];
        rise   <= sync_ff[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pynq_z2_io_ctrl.sv
// Pynq-Z2 board I/O block: AXI4-Lite slave, debounced buttons with maskable
// interrupt, per-channel LED brightness. PWM dimming needs PYNQ_Z2_IO_PWM_EN;
// without it each LED is simply on when its duty is non-zero.
//   state     | meaning (write and read channels each run one copy)
//   AXI_IDLE  | waiting for address (and data) valid
//   AXI_READY | ready asserted, handshake completes this cycle
//   AXI_RESP  | response valid, held until the master accepts it
module pynq_z2_io_ctrl
  import pynq_z2_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int N_LED     = 4,
  parameter int DB_CYCLES = 1250000,
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [7:0]           s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  input  logic [N_BTN-1:0]     btn_in,
  output logic [N_LED-1:0]     led_out,
  output logic                 irq
);

  axi_ch_t wr_st, wr_st_nx, rd_st, rd_st_nx;
  logic    wr_en, rd_en;

  logic [N_BTN-1:0]     btn_state, btn_rise, irq_status, irq_enable, w1c_mask;
  logic [PWM_WIDTH-1:0] duty [N_LED];
  logic [5:0]           wr_word, rd_word;
  logic [31:0]          rd_mux;
  logic                 unused_bits;

  assign wr_word     = s_axi_awaddr[7:2];
  assign rd_word     = s_axi_araddr[7:2];
  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;
  assign unused_bits = ^{s_axi_wstrb, s_axi_wdata, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_st <= AXI_IDLE;
      rd_st <= AXI_IDLE;
    end else begin
      wr_st <= wr_st_nx;
      rd_st <= rd_st_nx;
    end
  end

  always_comb begin
    wr_st_nx      = wr_st;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    wr_en         = 1'b0;
    case (wr_st)
      AXI_IDLE: if (s_axi_awvalid && s_axi_wvalid) wr_st_nx = AXI_READY;
      AXI_READY: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        if (s_axi_awvalid && s_axi_wvalid) begin
          wr_en    = 1'b1;
          wr_st_nx = AXI_RESP;
        end else begin
          wr_st_nx = AXI_IDLE;
        end
      end
      AXI_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_st_nx = AXI_IDLE;
      end
      default: wr_st_nx = AXI_IDLE;
    endcase
  end

  always_comb begin
    rd_st_nx      = rd_st;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    rd_en         = 1'b0;
    case (rd_st)
      AXI_IDLE: if (s_axi_arvalid) rd_st_nx = AXI_READY;
      AXI_READY: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          rd_en    = 1'b1;
          rd_st_nx = AXI_RESP;
        end else begin
          rd_st_nx = AXI_IDLE;
        end
      end
      AXI_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) rd_st_nx = AXI_IDLE;
      end
      default: rd_st_nx = AXI_IDLE;
    endcase
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    pynq_z2_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .din    (btn_in[g]),
      .stable (btn_state[g]),
      .rise   (btn_rise[g])
    );
  end

  assign w1c_mask = (wr_en && wr_word == W_IRQ_STATUS) ? s_axi_wdata[N_BTN-1:0] : '0;

  // OR-ing the rise after the clear makes a same-cycle press win over W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_status <= '0;
      irq_enable <= '0;
      irq        <= 1'b0;
      for (int i = 0; i < N_LED; i++) duty[i] <= '0;
    end else begin
      irq        <= |(irq_status & irq_enable);
      irq_status <= (irq_status & ~w1c_mask) | btn_rise;
      if (wr_en && wr_word == W_IRQ_ENABLE) irq_enable <= s_axi_wdata[N_BTN-1:0];
      for (int i = 0; i < N_LED; i++) begin
        if (wr_en && wr_word == 6'(W_LED_DUTY + i)) duty[i] <= s_axi_wdata[PWM_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      W_BTN_STATE:  rd_mux[N_BTN-1:0] = btn_state;
      W_IRQ_STATUS: rd_mux[N_BTN-1:0] = irq_status;
      W_IRQ_ENABLE: rd_mux[N_BTN-1:0] = irq_enable;
      W_INFO:       rd_mux = info_word(N_LED, N_BTN, PWM_WIDTH);
      default:      rd_mux = '0;
    endcase
    for (int i = 0; i < N_LED; i++) begin
      if (rd_word == 6'(W_LED_DUTY + i)) rd_mux[PWM_WIDTH-1:0] = duty[i];
    end
  end

  // Sampled at the handshake edge, so a concurrent W1C still reads pre-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_axi_rdata <= '0;
    else if (rd_en) s_axi_rdata <= rd_mux;
  end

`ifdef PYNQ_Z2_IO_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      led_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < N_LED; i++) led_out[i] <= (pwm_cnt < duty[i]);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) led_out[i] <= |duty[i];
    end
  end
`endif

endmodule
